// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and access sequencer for a single-ported memory
module mem_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    output logic                  p0_ack_o,

    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  p1_ack_o,

    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  any_req;
    logic                  winner;
    logic                  start;

    // last_grant remembers the most recent winner so ties alternate in round-robin mode
    logic                  last_grant;
    logic                  grant_lat;
    logic                  we_lat;
    logic [ADDR_WIDTH-1:0] addr_lat;
    logic [DATA_WIDTH-1:0] wdata_lat;
    logic [DATA_WIDTH-1:0] resp_data;

    assign any_req = p0_req_i | p1_req_i;
    assign start   = (state == IDLE) && any_req;

    // Pick the port that wins this IDLE cycle (0 = port 0, 1 = port 1)
    always_comb begin
        winner = 1'b0;
        if (p0_req_i && p1_req_i) begin
            if (FIXED_PRIORITY != 0) begin
                winner = 1'b0;
            end else begin
                winner = ~last_grant;
            end
        end else if (p1_req_i) begin
            winner = 1'b1;
        end
    end

    // Next-state logic: one access, optional wait states, one response cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning request once, at the IDLE to ACCESS hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_lat  <= 1'b0;
            we_lat     <= 1'b0;
            addr_lat   <= '0;
            wdata_lat  <= '0;
        end else if (start) begin
            last_grant <= winner;
            grant_lat  <= winner;
            we_lat     <= winner ? p1_we_i    : p0_we_i;
            addr_lat   <= winner ? p1_addr_i  : p0_addr_i;
            wdata_lat  <= winner ? p1_wdata_i : p0_wdata_i;
        end
    end

    // Memory side: enables only in ACCESS, and never while reset is asserted
    always_comb begin
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        if (state == ACCESS) begin
            mem_rd_en_o = ~we_lat & ~rst;
            mem_wr_en_o = we_lat & ~rst;
            mem_addr_o  = addr_lat;
            mem_data_o  = wdata_lat;
        end
    end

    // Requester side: ack and data go to the granted port only, during RESP
    always_comb begin
        p0_ack_o   = 1'b0;
        p1_ack_o   = 1'b0;
        p0_rdata_o = '0;
        p1_rdata_o = '0;
        resp_data  = we_lat ? '0 : mem_data_i;
        if (state == RESP) begin
            if (grant_lat) begin
                p1_ack_o   = 1'b1;
                p1_rdata_o = resp_data;
            end else begin
                p0_ack_o   = 1'b1;
                p0_rdata_o = resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic        mem_rd_en, mem_wr_en, mem_ack;
    logic [31:0] mem_addr, mem_data, mem_rdata;

    logic        fp_p0_ack, fp_p1_ack, fp_rd_en, fp_wr_en, fp_ack_in;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_addr, fp_data, fp_rdata_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIORITY(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_rdata_o(p0_rdata), .p0_ack_o(p0_ack),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_rdata_o(p1_rdata), .p1_ack_o(p1_ack),
        .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    mem_arbiter #(.FIXED_PRIORITY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_rdata_o(fp_p0_rdata), .p0_ack_o(fp_p0_ack),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_rdata_o(fp_p1_rdata), .p1_ack_o(fp_p1_ack),
        .mem_rd_en_o(fp_rd_en), .mem_wr_en_o(fp_wr_en), .mem_addr_o(fp_addr),
        .mem_data_o(fp_data), .mem_data_i(fp_rdata_in), .mem_ack_i(fp_ack_in)
    );

    // Memory stand-in: write on acknowledged write, registered read data
    logic [31:0] mem  [0:63];
    logic [31:0] gold [0:63];
    int          ack_delay  = 0;
    bit          ack_always = 1'b0;
    int          acc_cnt    = 0;

    assign mem_ack   = ack_always | ((mem_rd_en | mem_wr_en) && (acc_cnt >= ack_delay));
    assign fp_ack_in = fp_rd_en | fp_wr_en;

    always @(posedge clk) begin
        if (mem_wr_en && mem_ack) mem[mem_addr[7:2]] = mem_data;
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:2]];
        acc_cnt <= ((mem_rd_en | mem_wr_en) && !mem_ack) ? acc_cnt + 1 : 0;
    end

    always @(posedge clk) begin
        if (fp_rd_en) fp_rdata_in <= mem[fp_addr[7:2]];
    end

    // Reference model: one transaction at a time, tracked as "waiting for memory" then "responding"
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    int          m_port = 0;
    int          m_last = 1;
    bit          m_we   = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_last = 1;
        end else if (!m_busy) begin
            if (p0_req || p1_req) begin
                if (p0_req && p1_req) m_port = 1 - m_last;
                else                  m_port = p0_req ? 0 : 1;
                m_we    = (m_port == 0) ? p0_we    : p1_we;
                m_addr  = (m_port == 0) ? p0_addr  : p1_addr;
                m_wdata = (m_port == 0) ? p0_wdata : p1_wdata;
                m_last  = m_port;
                m_busy  = 1'b1;
                m_resp  = 1'b0;
            end
        end else if (!m_resp) begin
            if (mem_ack) begin
                if (m_we) gold[m_addr[7:2]] = m_wdata;
                m_rdata = m_we ? 32'h0 : gold[m_addr[7:2]];
                m_resp  = 1'b1;
            end
        end else begin
            m_busy = 1'b0;
            m_resp = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    bit chk_en    = 1'b0;
    int rd_cycles = 0;
    bit e_acc, e_resp;

    always @(negedge clk) begin
        if (chk_en) begin
            e_acc  = m_busy && !m_resp;
            e_resp = m_busy && m_resp;
            check("p0_ack", 32'(p0_ack), 32'(e_resp && m_port == 0));
            check("p1_ack", 32'(p1_ack), 32'(e_resp && m_port == 1));
            check("p0_rdata", p0_rdata, (e_resp && m_port == 0) ? m_rdata : 32'h0);
            check("p1_rdata", p1_rdata, (e_resp && m_port == 1) ? m_rdata : 32'h0);
            check("mem_rd_en", 32'(mem_rd_en), 32'(e_acc && !m_we && !rst));
            check("mem_wr_en", 32'(mem_wr_en), 32'(e_acc && m_we && !rst));
            if (e_acc) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_data", mem_data, m_wdata);
            end
            if (mem_rd_en) rd_cycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        mem[idx]  = val;
        gold[idx] = val;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One request from one port, held until ack; checks latency and returned data
    task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat,
                             input logic [31:0] exp_rdata, input string name);
        int lat;
        step();
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
        lat = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ack : p1_ack) begin
                lat = c;
                check({name, " rdata"}, (port == 0) ? p0_rdata : p1_rdata, exp_rdata);
                break;
            end
            step();
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        step();
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0, n1, lat, fp0, acks, rd0;
        int          ord [$];
        logic [31:0] dat [$];

        for (int i = 0; i < 64; i++) preload(i, 32'h0);
        preload(0,  32'hA0A0_0000);
        preload(1,  32'hB1B1_0004);
        preload(4,  32'hDEAD_BEEF);
        preload(12, 32'h5555_AAAA);
        preload(16, 32'h4040_4040);
        preload(17, 32'h4444_4444);
        mem_rdata = '0;
        fp_rdata_in = '0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

        reset_dut();
        @(negedge clk);
        check("reset p0_ack", 32'(p0_ack), 0);
        check("reset p1_ack", 32'(p1_ack), 0);
        check("reset p0_rdata", p0_rdata, 0);
        check("reset p1_rdata", p1_rdata, 0);
        check("reset rd_en", 32'(mem_rd_en), 0);
        check("reset wr_en", 32'(mem_wr_en), 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_data", mem_data, 0);
        chk_en = 1'b1;

        // Single read, with mem_ack_i held high outside ACCESS as well
        step();
        ack_always = 1'b1;
        rd0 = rd_cycles;
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        @(negedge clk);
        check("read N rd_en", 32'(mem_rd_en), 0);
        step();
        @(negedge clk);
        check("read N+1 rd_en", 32'(mem_rd_en), 1);
        check("read N+1 addr", mem_addr, 32'h10);
        step();
        @(negedge clk);
        check("read N+2 p0_ack", 32'(p0_ack), 1);
        check("read N+2 p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        check("read N+2 p1_ack", 32'(p1_ack), 0);
        check("read rd_en cycles", 32'(rd_cycles - rd0), 1);
        step();
        p0_req = 0;
        ack_always = 1'b0;

        // Write then read back through port 1
        do_access(1, 1'b1, 32'h20, 32'h1234_5678, 2, 32'h0, "p1 write");
        do_access(1, 1'b0, 32'h20, 32'h0, 2, 32'h1234_5678, "p1 read");

        // Three wait states: enables held four cycles, ack at N+5
        ack_delay = 3;
        rd0 = rd_cycles;
        do_access(0, 1'b0, 32'h10, 32'h0, 5, 32'hDEAD_BEEF, "wait read");
        check("wait rd_en cycles", 32'(rd_cycles - rd0), 4);
        ack_delay = 0;

        // Address change after grant is ignored
        step();
        p0_req = 1; p0_we = 0; p0_addr = 32'h40;
        step();
        p0_addr = 32'h44;
        @(negedge clk);
        check("late addr mem_addr", mem_addr, 32'h40);
        step();
        @(negedge clk);
        check("late addr p0_ack", 32'(p0_ack), 1);
        check("late addr p0_rdata", p0_rdata, 32'h4040_4040);
        step();
        p0_req = 0;

        // Reset during the ACCESS cycle of a write
        step();
        p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'hFFFF_FFFF;
        step();
        rst = 1'b1;
        p0_req = 0; p0_we = 0;
        @(negedge clk);
        check("rst wr_en forced", 32'(mem_wr_en), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post-rst wr_en", 32'(mem_wr_en), 0);
        check("post-rst mem_addr", mem_addr, 0);
        check("post-rst mem_data", mem_data, 0);
        check("post-rst p0_ack", 32'(p0_ack), 0);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            if (p0_ack) acks++;
        end
        check("rst no ack", 32'(acks), 0);
        check("rst mem word", mem[12], 32'h5555_AAAA);

        // Round-robin contention, four reads each
        step();
        p0_req = 1; p0_we = 0; p0_addr = 32'h0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h4;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 60 && (p0_req || p1_req); c++) begin
            @(negedge clk);
            if (p0_ack) begin ord.push_back(0); dat.push_back(p0_rdata); n0++; end
            if (p1_ack) begin ord.push_back(1); dat.push_back(p1_rdata); n1++; end
            step();
            if (n0 == 4) p0_req = 0;
            if (n1 == 4) p1_req = 0;
        end
        p0_req = 0; p1_req = 0;
        check("rr grant count", 32'(ord.size()), 8);
        for (int i = 0; i < ord.size(); i++) begin
            check("rr grant order", 32'(ord[i]), 32'(i % 2));
            check("rr rdata", dat[i], (ord[i] == 0) ? 32'hA0A0_0000 : 32'hB1B1_0004);
        end

        // Fixed priority: port 1 waits until port 0 drops its request
        reset_dut();
        step();
        p0_req = 1; p0_we = 0; p0_addr = 32'h0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h4;
        fp0 = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("fp p1 held off", 32'(fp_p1_ack), 0);
            if (fp_p0_ack) begin
                fp0++;
                check("fp p0_rdata", fp_p0_rdata, 32'hA0A0_0000);
            end
            step();
        end
        check("fp p0 grants", 32'(fp0), 3);
        p0_req = 0;
        lat = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (fp_p1_ack) begin
                lat = c;
                check("fp p1_rdata", fp_p1_rdata, 32'hB1B1_0004);
                break;
            end
            step();
        end
        check("fp p1 latency", 32'(lat), 2);
        step();
        p1_req = 0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
